// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide two's-complement add/subtract computed one nibble per clock on a single
// 4-bit ripple-carry slice, LSB nibble first, with a one-cycle done pulse.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    logic [IW-1:0]   idx_reg;
    logic            carry_reg;
    logic            mode_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    partial_reg;

    logic [3:0]      a_n;
    logic [3:0]      b_n;
    logic [3:0]      sum_n;
    logic [4:0]      c;
    logic [W-1:0]    partial_next;
    logic            last;

    assign a_n  = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_n  = b_reg[{idx_reg, 2'b00} +: 4] ^ {4{mode_reg}};
    assign c[0] = carry_reg;
    assign last = (idx_reg == IW'(NIBBLES - 1));

    // The shared 4-bit ripple-carry slice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign sum_n[gi] = a_n[gi] ^ b_n[gi] ^ c[gi];
            assign c[gi+1]   = (a_n[gi] & b_n[gi]) | (c[gi] & (a_n[gi] ^ b_n[gi]));
        end
    endgenerate

    // Partial result with the current nibble merged, so the final edge can
    // publish the complete word in one step.
    always_comb begin
        partial_next = partial_reg;
        partial_next[{idx_reg, 2'b00} +: 4] = sum_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            mode_reg    <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            partial_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            cout        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        mode_reg    <= mode;
                        carry_reg   <= mode;
                        idx_reg     <= '0;
                        partial_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    partial_reg <= partial_next;
                    carry_reg   <= c[4];
                    if (last) begin
                        idx_reg   <= '0;
                        result    <= partial_next;
                        cout      <= c[4];
                        overflow  <= (a_n[3] == b_n[3]) & (sum_n[3] != a_n[3]);
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed-vector bench for nibble_serial_addsub_ctrl with hand-computed results.
module tb_nibble_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One transaction: start for one edge, scramble inputs, time done and busy.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vm, input logic [15:0] er, input logic ec, input logic eo,
                          input bit hold_start);
        int done_at = 0;
        int busy_cnt = 0;
        int n_done = 0;
        logic [15:0] prev_res;
        logic stable = 1'b1;
        @(negedge clk);
        prev_res = result;
        a = va; b = vb; mode = vm; start = 1'b1;
        @(posedge clk);
        #1;
        if (hold_start) begin
            a = 16'hAAAA; b = 16'h5555; mode = 1'b1;
        end else begin
            start = 1'b0; a = ~va; b = ~vb; mode = ~vm;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
            if (done_at == 0 && result !== prev_res) stable = 1'b0;
            if (done_at == k) begin
                check({tag, " result"}, 32'(result), 32'(er));
                check({tag, " cout"}, 32'(cout), 32'(ec));
                check({tag, " ovf"}, 32'(overflow), 32'(eo));
            end
        end
        check({tag, " done_latency"}, 32'(done_at), 32'd5);
        check({tag, " done_pulses"}, 32'(n_done), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd5);
        check({tag, " result_held"}, 32'(stable), 32'd1);
        check({tag, " idle_after"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_carry", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        // start held high through the first RUN cycles with new operands: must be ignored
        run_op("busy_prot", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

        // Abort in the second RUN cycle.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort result", 32'(result), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        begin
            int seen = 0;
            repeat (2) begin
                @(negedge clk);
                if (done) seen++;
            end
            rst_n = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("abort no_done", 32'(seen), 32'd0);
        end
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
